// File: rtl/addsub_rr_arbiter_pkg.sv
// rtl/addsub_rr_arbiter_pkg.sv - shared constants for the round-robin add/subtract arbiter
// Purpose: default datapath width, op encoding and overflow counter sizing.
package addsub_rr_arbiter_pkg;

   localparam int ADDSUB_WIDTH = 8;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   localparam int                   OVF_CNT_W   = 8;
   localparam logic [OVF_CNT_W-1:0] OVF_CNT_MAX = '1;

endpackage

// File: rtl/addsub_core.sv
// rtl/addsub_core.sv - combinational signed add/subtract with overflow detect
// Ports: a, b (operands), op (OP_ADD/OP_SUB) -> sum (mod 2^WIDTH), overflow (signed).
module addsub_core
   import addsub_rr_arbiter_pkg::*;
#(
   parameter int WIDTH = ADDSUB_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             op,
   output logic [WIDTH-1:0] sum,
   output logic             overflow
);

   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] cin_vec;

   // Subtraction is a + ~b + 1; the carry-out is dropped by the truncating add.
   assign b_eff   = (op == OP_SUB) ? ~b : b;
   assign cin_vec = {{(WIDTH-1){1'b0}}, (op == OP_SUB)};
   assign sum     = a + b_eff + cin_vec;

   // Overflow: both effective operands share a sign that the result does not.
   assign overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/addsub_rr_arbiter.sv
// rtl/addsub_rr_arbiter.sv - two-requester round-robin front end for a shared add/sub core
// Ports: clk, rst_n (async active-low); reqN_valid/ready/a/b/op per requester;
//        rsp_valid/ready/sum/overflow/id single-entry result buffer;
//        ovf_count0/1 saturating per-requester overflow counters.
module addsub_rr_arbiter
   import addsub_rr_arbiter_pkg::*;
#(
   parameter int WIDTH = ADDSUB_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req0_valid,
   output logic                 req0_ready,
   input  logic [WIDTH-1:0]     req0_a,
   input  logic [WIDTH-1:0]     req0_b,
   input  logic                 req0_op,
   input  logic                 req1_valid,
   output logic                 req1_ready,
   input  logic [WIDTH-1:0]     req1_a,
   input  logic [WIDTH-1:0]     req1_b,
   input  logic                 req1_op,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [WIDTH-1:0]     rsp_sum,
   output logic                 rsp_overflow,
   output logic                 rsp_id,
   output logic [OVF_CNT_W-1:0] ovf_count0,
   output logic [OVF_CNT_W-1:0] ovf_count1
);

   logic             prio;
   logic             can_accept;
   logic             winner;
   logic             grant;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;
   logic             sel_op;
   logic [WIDTH-1:0] core_sum;
   logic             core_ovf;

   assign can_accept = !rsp_valid || rsp_ready;

   // Contention goes to prio; otherwise whichever side is valid (idle defaults to 0,
   // harmless because grant is gated by any-valid).
   assign winner = (req0_valid && req1_valid) ? prio : req1_valid;
   assign grant  = can_accept && (req0_valid || req1_valid);

   assign req0_ready = grant && !winner;
   assign req1_ready = grant &&  winner;

   assign sel_a  = winner ? req1_a  : req0_a;
   assign sel_b  = winner ? req1_b  : req0_b;
   assign sel_op = winner ? req1_op : req0_op;

   addsub_core #(.WIDTH(WIDTH)) u_core (
      .a        (sel_a),
      .b        (sel_b),
      .op       (sel_op),
      .sum      (core_sum),
      .overflow (core_ovf)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio         <= 1'b0;
         rsp_valid    <= 1'b0;
         rsp_sum      <= '0;
         rsp_overflow <= 1'b0;
         rsp_id       <= 1'b0;
      end else if (grant) begin
         prio         <= ~winner;
         rsp_valid    <= 1'b1;
         rsp_sum      <= core_sum;
         rsp_overflow <= core_ovf;
         rsp_id       <= winner;
      end else if (rsp_ready) begin
         // Drain without reload: payload is left stale on purpose.
         rsp_valid    <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_count0 <= '0;
         ovf_count1 <= '0;
      end else if (grant && core_ovf) begin
         if (!winner && ovf_count0 != OVF_CNT_MAX) ovf_count0 <= ovf_count0 + 1'b1;
         if ( winner && ovf_count1 != OVF_CNT_MAX) ovf_count1 <= ovf_count1 + 1'b1;
      end
   end

endmodule
